// File: rtl/interboard_pkg.sv
// interboard_pkg: shared message types, framing helpers and FSM encodings for the interboard hub.
package interboard_pkg;
    localparam logic [2:0] MSG_RST    = 3'd0;
    localparam logic [2:0] MSG_START  = 3'd1;
    localparam logic [2:0] MSG_SELECT = 3'd2;
    localparam logic [2:0] MSG_GUESS  = 3'd3;
    localparam logic [2:0] MSG_WIN    = 3'd4;

    typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_REL, TX_DONE} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_CAP, RX_WAITLOW} rx_state_e;
    typedef enum logic [1:0] {HUB_OFF, HUB_IDLE, HUB_BUSY} hub_state_e;

    function automatic int payload_w(input int type_w, input int num_w);
        return type_w + num_w;
    endfunction

    function automatic int beats(input int pw, input int dw);
        return (pw + dw - 1) / dw;
    endfunction
endpackage

// File: rtl/interboard_lane.sv
// interboard_lane: one peer channel with input synchronisers, multi-beat 4-phase TX and RX
// handshakes, a message holding register and per-direction handshake timeouts.
module interboard_lane
    import interboard_pkg::*;
#(
    parameter int DATA_W      = 6,
    parameter int PAYLOAD_W   = 8,
    parameter int BEATS       = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic                    ack_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic                    req_o,
    output logic                    ack_o,
    output logic [DATA_W-1:0]       data_o,
    input  logic                    tx_start_i,
    input  logic                    tx_clr_i,
    input  logic [BEATS*DATA_W-1:0] tx_pay_i,
    output logic                    tx_busy_o,
    input  logic                    rx_clr_i,
    output logic                    rx_pend_o,
    output logic [PAYLOAD_W-1:0]    rx_msg_o,
    output logic                    err_o
);
    localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic [1:0]              req_sync_q, ack_sync_q;
    tx_state_e               tx_q, tx_d;
    rx_state_e               rx_q, rx_d;
    logic [BW-1:0]           tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [BEATS*DATA_W-1:0] buf_q, buf_d;
    logic [PAYLOAD_W-1:0]    hold_q, hold_d;
    logic                    pend_q, pend_d, err_q;
    logic [CW-1:0]           tx_cnt_q, rx_cnt_q;
    logic                    req_s, ack_s, tx_to, rx_to;

    assign req_s     = req_sync_q[1];
    assign ack_s     = ack_sync_q[1];
    assign tx_to     = (tx_q == TX_REQ || tx_q == TX_REL) && tx_cnt_q == CNT_MAX;
    assign rx_to     = rx_q == RX_WAITLOW && rx_cnt_q == CNT_MAX;
    assign req_o     = tx_q == TX_REQ;
    assign ack_o     = rx_q == RX_CAP || rx_q == RX_WAITLOW;
    assign data_o    = data_q;
    assign tx_busy_o = tx_q == TX_SETUP || tx_q == TX_REQ || tx_q == TX_REL;
    assign rx_pend_o = pend_q;
    assign rx_msg_o  = hold_q;
    assign err_o     = err_q;

    always_comb begin
        tx_d      = tx_q;
        tx_beat_d = tx_beat_q;
        data_d    = data_q;
        case (tx_q)
            TX_IDLE: if (tx_start_i) begin
                tx_d      = TX_SETUP;
                tx_beat_d = '0;
                data_d    = tx_pay_i[DATA_W-1:0];
            end
            TX_SETUP: tx_d = TX_REQ;
            TX_REQ: tx_d = tx_to ? TX_IDLE : ack_s ? TX_REL : TX_REQ;
            TX_REL: if (tx_to) tx_d = TX_IDLE;
            else if (!ack_s) begin
                tx_d = tx_beat_q == LAST ? TX_DONE : TX_SETUP;
                if (tx_beat_q != LAST) begin
                    tx_beat_d = tx_beat_q + 1'b1;
                    data_d    = DATA_W'(tx_pay_i >> (DATA_W * (int'(tx_beat_q) + 1)));
                end
            end
            TX_DONE: if (tx_clr_i) tx_d = TX_IDLE;
            default: tx_d = TX_IDLE;
        endcase
    end

    // beat 0 of a new message waits while the previous one is still undelivered
    always_comb begin
        rx_d      = rx_q;
        rx_beat_d = rx_beat_q;
        buf_d     = buf_q;
        hold_d    = hold_q;
        pend_d    = pend_q & ~rx_clr_i;
        case (rx_q)
            RX_IDLE: if (req_s && (rx_beat_q != '0 || !pend_q)) begin
                rx_d = RX_CAP;
                buf_d[int'(rx_beat_q)*DATA_W +: DATA_W] = data_i;
                rx_beat_d = rx_beat_q == LAST ? '0 : rx_beat_q + 1'b1;
                if (rx_beat_q == LAST) begin
                    hold_d = buf_d[PAYLOAD_W-1:0];
                    pend_d = 1'b1;
                end
            end
            RX_CAP: rx_d = RX_WAITLOW;
            RX_WAITLOW: if (rx_to || !req_s) rx_d = RX_IDLE;
            default: rx_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
            tx_q       <= TX_IDLE;
            rx_q       <= RX_IDLE;
            tx_beat_q  <= '0;
            rx_beat_q  <= '0;
            data_q     <= '0;
            buf_q      <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
        end else begin
            req_sync_q <= {req_sync_q[0], req_i};
            ack_sync_q <= {ack_sync_q[0], ack_i};
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            tx_beat_q  <= tx_beat_d;
            rx_beat_q  <= rx_beat_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            err_q      <= err_q | tx_to | rx_to;
            tx_cnt_q   <= tx_d == tx_q ? tx_cnt_q + 1'b1 : '0;
            rx_cnt_q   <= rx_d == rx_q ? rx_cnt_q + 1'b1 : '0;
        end
    end
endmodule

// File: rtl/interboard_hub.sv
// interboard_hub: game-master hub to N_CH peer boards; parallel multi-beat transmit with
// completion tracking, per-channel reception and round-robin delivery of received messages.
module interboard_hub
    import interboard_pkg::*;
#(
    parameter int                N_CH        = 3,
    parameter int                DATA_W      = 6,
    parameter int                TYPE_W      = 3,
    parameter int                NUM_W       = 5,
    parameter int                TIMEOUT_CYC = 1000000,
    parameter logic [TYPE_W-1:0] RST_TYPE    = TYPE_W'(MSG_RST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [N_CH-1:0]          tx_mask,
    input  logic [TYPE_W-1:0]        tx_msg_type,
    input  logic [NUM_W-1:0]         tx_number,
    output logic                     tx_done,
    output logic                     rx_en,
    output logic [$clog2(N_CH)-1:0]  rx_src,
    output logic [TYPE_W-1:0]        rx_msg_type,
    output logic [NUM_W-1:0]         rx_number,
    output logic                     rx_rst,
    output logic [N_CH-1:0]          link_err,
    input  logic [N_CH-1:0]          Request_in,
    input  logic [N_CH-1:0]          Ack_in,
    input  logic [N_CH*DATA_W-1:0]   inter_data_in,
    output logic [N_CH-1:0]          Request_out,
    output logic [N_CH-1:0]          Ack_out,
    output logic [N_CH*DATA_W-1:0]   inter_data_out
);
    localparam int PW    = payload_w(TYPE_W, NUM_W);
    localparam int BEATS = beats(PW, DATA_W);
    localparam int PADW  = BEATS * DATA_W;
    localparam int SW    = $clog2(N_CH);

    hub_state_e        st_q, st_d;
    logic [PADW-1:0]   pay_q, pay;
    logic [N_CH-1:0]   busy, pend, gnt_clr;
    logic [PW-1:0]     msg [N_CH];
    logic [SW-1:0]     ptr_q, gnt, rx_src_q;
    logic              gnt_v, accept, rx_en_q, rx_rst_q;
    logic [TYPE_W-1:0] rx_type_q;
    logic [NUM_W-1:0]  rx_num_q;

    assign tx_ready    = st_q == HUB_IDLE;
    assign accept      = tx_valid && tx_ready;
    assign tx_done     = st_q == HUB_BUSY && busy == '0;
    assign pay         = st_q == HUB_IDLE ? PADW'({tx_msg_type, tx_number}) : pay_q;
    assign gnt_clr     = gnt_v ? N_CH'(1) << gnt : '0;
    assign rx_en       = rx_en_q;
    assign rx_src      = rx_src_q;
    assign rx_msg_type = rx_type_q;
    assign rx_number   = rx_num_q;
    assign rx_rst      = rx_rst_q;

    always_comb begin
        st_d = st_q;
        case (st_q)
            HUB_OFF:  st_d = HUB_IDLE;
            HUB_IDLE: if (accept) st_d = HUB_BUSY;
            HUB_BUSY: if (tx_done) st_d = HUB_IDLE;
            default:  st_d = HUB_OFF;
        endcase
    end

    // scan downwards so the pending lane closest after the pointer wins
    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend[(int'(ptr_q) + i) % N_CH]) begin
                gnt   = SW'((int'(ptr_q) + i) % N_CH);
                gnt_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= HUB_OFF;
            pay_q     <= '0;
            ptr_q     <= '0;
            rx_en_q   <= 1'b0;
            rx_rst_q  <= 1'b0;
            rx_src_q  <= '0;
            rx_type_q <= '0;
            rx_num_q  <= '0;
        end else begin
            st_q     <= st_d;
            rx_en_q  <= gnt_v;
            rx_rst_q <= gnt_v && msg[gnt][PW-1 -: TYPE_W] == RST_TYPE;
            if (accept) pay_q <= pay;
            if (gnt_v) begin
                ptr_q     <= gnt == SW'(N_CH - 1) ? '0 : gnt + 1'b1;
                rx_src_q  <= gnt;
                rx_type_q <= msg[gnt][PW-1 -: TYPE_W];
                rx_num_q  <= msg[gnt][NUM_W-1:0];
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        interboard_lane #(
            .DATA_W     (DATA_W),
            .PAYLOAD_W  (PW),
            .BEATS      (BEATS),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .req_i     (Request_in[c]),
            .ack_i     (Ack_in[c]),
            .data_i    (inter_data_in[c*DATA_W +: DATA_W]),
            .req_o     (Request_out[c]),
            .ack_o     (Ack_out[c]),
            .data_o    (inter_data_out[c*DATA_W +: DATA_W]),
            .tx_start_i(accept && tx_mask[c]),
            .tx_clr_i  (tx_done),
            .tx_pay_i  (pay),
            .tx_busy_o (busy[c]),
            .rx_clr_i  (gnt_clr[c]),
            .rx_pend_o (pend[c]),
            .rx_msg_o  (msg[c]),
            .err_o     (link_err[c])
        );
    end
endmodule

// File: tb/tb_interboard_hub.sv
// tb_interboard_hub: directed and randomized checks of the hub against peer-board models
// and an arithmetic reference for framing, delivery order and timeouts.
module tb_interboard_hub;
    localparam int N     = 3;
    localparam int DW    = 6;
    localparam int TW    = 3;
    localparam int NW    = 5;
    localparam int TO    = 16;
    localparam int BEATS = (TW + NW + DW - 1) / DW;

    logic          clk = 1'b0, rst = 1'b1;
    logic          tx_valid = 1'b0, tx_ready, tx_done, rx_en, rx_rst;
    logic [N-1:0]  tx_mask = '0, link_err, Request_in = '0, Ack_in = '0, Request_out, Ack_out;
    logic [TW-1:0] tx_msg_type = '0, rx_msg_type;
    logic [NW-1:0] tx_number = '0, rx_number;
    logic [1:0]    rx_src;
    logic [N*DW-1:0] inter_data_in = '0, inter_data_out;

    int tests = 0, fails = 0;
    logic [N-1:0]  ack_en = '1;
    logic [DW-1:0] got [N][64];
    int            got_n [N] = '{default: 0};
    int            done_cnt = 0;
    logic [10:0]   rx_log [64];
    int            rx_wr = 0, rx_rd = 0;
    int            lat [N][BEATS];
    int            rr = 0;

    interboard_hub #(.N_CH(N), .DATA_W(DW), .TYPE_W(TW), .NUM_W(NW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_mask(tx_mask),
        .tx_msg_type(tx_msg_type), .tx_number(tx_number), .tx_done(tx_done), .rx_en(rx_en),
        .rx_src(rx_src), .rx_msg_type(rx_msg_type), .rx_number(rx_number), .rx_rst(rx_rst),
        .link_err(link_err), .Request_in(Request_in), .Ack_in(Ack_in),
        .inter_data_in(inter_data_in), .Request_out(Request_out), .Ack_out(Ack_out),
        .inter_data_out(inter_data_out)
    );

    always #5 clk = ~clk;

    // peer boards on the TX side: ack each request, record the beat seen on the wire
    always @(negedge clk)
        for (int c = 0; c < N; c++)
            if (ack_en[c] && Request_out[c] && !Ack_in[c]) begin
                got[c][got_n[c] % 64] = inter_data_out[c*DW +: DW];
                got_n[c]++;
                Ack_in[c] = 1'b1;
            end else if (!Request_out[c]) Ack_in[c] = 1'b0;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rx_en) begin
            rx_log[rx_wr % 64] = {rx_rst, rx_src, rx_msg_type, rx_number};
            rx_wr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input int c, input int k, input logic [DW-1:0] d);
        int n = 0;
        inter_data_in[c*DW +: DW] = d;
        tick();
        Request_in[c] = 1'b1;
        while (!Ack_out[c] && n < 50) begin tick(); n++; end
        lat[c][k] = n;
        Request_in[c] = 1'b0;
        n = 0;
        while (Ack_out[c] && n < 50) begin tick(); n++; end
    endtask

    task automatic send_msg(input int c, input int t, input int nm);
        int pl = t * (1 << NW) + nm;
        for (int k = 0; k < BEATS; k++) send_beat(c, k, DW'((pl >> (k * DW)) & ((1 << DW) - 1)));
    endtask

    task automatic wait_rx(input int want);
        int n = 0;
        while (rx_wr - rx_rd < want && n < 100) begin tick(); n++; end
    endtask

    task automatic expect_rx(input string tag, input int src, input int t, input int nm);
        logic [10:0] e = {t == 0, 2'(src), 3'(t), 5'(nm)};
        chk({tag, "_avail"}, 64'(rx_wr > rx_rd), 1);
        if (rx_wr > rx_rd) begin
            chk(tag, rx_log[rx_rd % 64], e);
            rx_rd++;
        end
        rr = (src + 1) % N;
    endtask

    task automatic do_tx(input string tag, input logic [N-1:0] m, input int t, input int nm, output int hi0);
        int base [N];
        int n = 0;
        int d0 = done_cnt;
        int pl = t * (1 << NW) + nm;
        while (!tx_ready && n < 200) begin tick(); n++; end
        chk({tag, "_ready"}, tx_ready, 1);
        for (int c = 0; c < N; c++) base[c] = got_n[c];
        tx_mask = m; tx_msg_type = TW'(t); tx_number = NW'(nm); tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk({tag, "_busy"}, {tx_ready, Request_out}, 0);
        chk({tag, "_done_early"}, tx_done, 64'(m == 0));
        tick();
        chk({tag, "_req_rise"}, Request_out, m);
        hi0 = int'(Request_out[0]);
        n = 0;
        while (done_cnt == d0 && n < 300) begin tick(); n++; hi0 += int'(Request_out[0]); end
        repeat (5) tick();
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 1);
        chk({tag, "_ready_back"}, tx_ready, 1);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("%s_nbeats%0d", tag, c), 64'(got_n[c] - base[c]), 64'((m[c] && ack_en[c]) ? BEATS : 0));
            for (int k = 0; k < got_n[c] - base[c] && k < BEATS; k++)
                chk($sformatf("%s_beat%0d_%0d", tag, c, k), got[c][(base[c] + k) % 64], 64'((pl >> (k * DW)) & ((1 << DW) - 1)));
        end
    endtask

    initial begin
        int hi, t, nm, c;
        int st [N];
        int sn [N];
        repeat (3) tick();
        chk("reset_outs", {tx_ready, tx_done, rx_en, rx_src, rx_msg_type, rx_number, rx_rst, link_err,
                           Request_out, Ack_out, inter_data_out}, 0);
        rst = 1'b0;
        tick();
        chk("ready_rise", tx_ready, 1);

        do_tx("tx101", 3'b101, 2, 17, hi);

        send_msg(1, 2, 17);
        for (int k = 0; k < BEATS; k++) chk($sformatf("ack_lat%0d", k), 64'(lat[1][k]), 3);
        wait_rx(1);
        expect_rx("rx_ch1", 1, 2, 17);

        nm = $urandom_range(0, 31);
        send_msg(2, 0, nm);
        wait_rx(1);
        expect_rx("rx_rsttype", 2, 0, nm);

        for (int r = 0; r < 2; r++) begin
            int p = rr;
            for (int i = 0; i < N; i++) begin st[i] = $urandom_range(0, 7); sn[i] = $urandom_range(0, 31); end
            fork
                send_msg(0, st[0], sn[0]);
                send_msg(1, st[1], sn[1]);
                send_msg(2, st[2], sn[2]);
            join
            wait_rx(N);
            for (int o = 0; o < N; o++) begin
                c = (p + o) % N;
                expect_rx($sformatf("rx_all%0d_%0d", r, o), c, st[c], sn[c]);
            end
        end

        for (int i = 0; i < 4; i++) begin
            t = $urandom_range(0, 7); nm = $urandom_range(0, 31);
            do_tx($sformatf("txr%0d", i), N'($urandom_range(1, 7)), t, nm, hi);
            c = $urandom_range(0, N - 1);
            t = $urandom_range(0, 7); nm = $urandom_range(0, 31);
            send_msg(c, t, nm);
            wait_rx(1);
            expect_rx($sformatf("rxr%0d", i), c, t, nm);
        end
        chk("no_err", link_err, 0);

        ack_en = 3'b110;
        do_tx("tx_to", 3'b111, $urandom_range(0, 7), $urandom_range(0, 31), hi);
        chk("to_req_cycles", 64'(hi), TO);
        chk("to_link_err", link_err, 3'b001);
        ack_en = '1;

        do_tx("tx_nomask", 3'b000, 5, 9, hi);

        t = $urandom_range(1, 7); nm = $urandom_range(0, 31);
        send_beat(2, 0, DW'(t * 32 + nm));
        inter_data_in[2*DW +: DW] = DW'((t * 32 + nm) >> DW);
        tick();
        Request_in[2] = 1'b1;
        repeat (3) tick();
        chk("mid_beat_ack", Ack_out[2], 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_outs", {tx_ready, tx_done, rx_en, rx_src, rx_msg_type, rx_number, rx_rst, link_err,
                             Request_out, Ack_out, inter_data_out}, 0);
        Request_in[2] = 1'b0;
        rst = 1'b0;
        tick();
        chk("ready_after_rst", tx_ready, 1);
        repeat (5) tick();
        chk("no_stray_rx", 64'(rx_wr - rx_rd), 0);
        t = $urandom_range(0, 7); nm = $urandom_range(0, 31);
        send_msg(2, t, nm);
        wait_rx(1);
        expect_rx("rx_after_rst", 2, t, nm);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
